// File: rtl/mem_split_arbiter_pkg.sv
// Shared constants for the split-transaction memory arbiter: host IDs and default owner-FIFO size.
package mem_split_arbiter_pkg;
  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
  localparam int RESP_FIFO_POW_DEFAULT = 4;
endpackage

// File: rtl/mem_split_arbiter_if.sv
// Split-transaction memory bus: one request channel plus a read-response channel.
// Handshake: a request transfers in any cycle with req & ack high; a requester holds
// req/we/addr/wdata/be stable until ack. Each read (we=0) is later answered by exactly one
// resp pulse carrying rdata, in request order. resp cannot be back-pressured.
interface mem_split_arbiter_if;
  import mem_split_arbiter_pkg::*;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, resp, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, resp, rdata);
endinterface

// File: rtl/mem_split_owner_fifo.sv
// In-order FIFO of 1-bit owner IDs, one entry per outstanding read.
module mem_split_owner_fifo
  import mem_split_arbiter_pkg::*;
#(
  parameter int POW = RESP_FIFO_POW_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int DEPTH = 1 << POW;

  logic           store [DEPTH];
  logic [POW-1:0] wptr;
  logic [POW-1:0] rptr;
  logic [POW:0]   count;

  always_ff @(posedge clk_i) begin
    if (push) store[wptr] <= push_id;
  end

  // Pointers wrap naturally at POW bits; count carries the extra bit to tell full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (POW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = store[rptr];
endmodule

// File: rtl/mem_split_arbiter.sv
// Round-robin 2:1 arbiter sharing one split-transaction memory port between instr and data hosts.
module mem_split_arbiter
  import mem_split_arbiter_pkg::*;
#(
  parameter int RESP_FIFO_POW = RESP_FIFO_POW_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_split_arbiter_if.slave   instr,
  mem_split_arbiter_if.slave   data,
  mem_split_arbiter_if.master  mem,
  output logic                 err_o
);
  logic last_grant;
  logic grant;
  logic elig_i;
  logic elig_d;
  logic xfer;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic head;

  // Writes bypass the full check; only reads need an owner slot.
  assign elig_i = instr.req & (instr.we | ~full);
  assign elig_d = data.req  & (data.we  | ~full);

  always_comb begin
    grant = PORT_INSTR;
    if (elig_i & elig_d) grant = ~last_grant;
    else if (elig_d)     grant = PORT_DATA;
  end

  always_comb begin
    mem.req   = elig_i | elig_d;
    mem.we    = instr.we;
    mem.addr  = instr.addr;
    mem.wdata = instr.wdata;
    mem.be    = instr.be;
    if (grant == PORT_DATA) begin
      mem.we    = data.we;
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
      mem.be    = data.be;
    end
  end

  assign xfer      = mem.req & mem.ack;
  assign instr.ack = xfer & (grant == PORT_INSTR);
  assign data.ack  = xfer & (grant == PORT_DATA);

  assign push = xfer & ~mem.we;
  assign pop  = mem.resp & ~empty;

  assign instr.resp  = pop & (head == PORT_INSTR);
  assign data.resp   = pop & (head == PORT_DATA);
  assign instr.rdata = mem.rdata;
  assign data.rdata  = mem.rdata;

  // Priority rotates only on a completed transfer, so a stalled grant keeps its priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= PORT_DATA;
      err_o      <= 1'b0;
    end else begin
      if (xfer) last_grant <= grant;
      if (mem.resp & empty) err_o <= 1'b1;
    end
  end

  mem_split_owner_fifo #(.POW(RESP_FIFO_POW)) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .push_id (grant),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );
endmodule
